// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported BRAM between instruction fetch and load/store.
// Build option DATA_PRIORITY_EN: the data port always wins contention; otherwise round-robin.
module mem_arbiter #(
  parameter int WORDS      = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  if_req_i,
  input  logic [WORDS-1:0]      if_addr_i,
  output logic                  if_ack_o,
  output logic [DATA_WIDTH-1:0] if_data_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [WORDS-1:0]      d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_data_i,
  output logic                  d_ack_o,
  output logic [DATA_WIDTH-1:0] d_data_o,
  output logic [WORDS-1:0]      mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  mem_wr_no,
  output logic                  mem_rd_no,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic                  busy_o,
  output logic                  grant_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t           state_q;
  logic             last_grant_q;
  logic             we_q;
  logic             win_data_d;
  logic [WORDS-1:0] addr_d;

`ifdef DATA_PRIORITY_EN
  logic unused_last_grant_s;
  assign unused_last_grant_s = last_grant_q;
`endif

  // Winner among the pending requests and the address it presents
  always_comb begin
    win_data_d = 1'b0;
    addr_d     = if_addr_i;
    if (if_req_i && d_req_i) begin
`ifdef DATA_PRIORITY_EN
      win_data_d = 1'b1;
`else
      win_data_d = ~last_grant_q;
`endif
    end else if (d_req_i) begin
      win_data_d = 1'b1;
    end else begin
      win_data_d = 1'b0;
    end
    if (win_data_d) begin
      addr_d = d_addr_i;
    end else begin
      addr_d = if_addr_i;
    end
  end

  // Access sequencer: IDLE samples, ACCESS strobes the memory, DONE acknowledges
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      mem_wr_no    <= 1'b1;
      mem_rd_no    <= 1'b1;
      if_ack_o     <= 1'b0;
      d_ack_o      <= 1'b0;
      busy_o       <= 1'b0;
      grant_o      <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      if_data_o    <= '0;
      d_data_o     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if_ack_o <= 1'b0;
          d_ack_o  <= 1'b0;
          if (if_req_i || d_req_i) begin
            state_q      <= ST_ACCESS;
            busy_o       <= 1'b1;
            grant_o      <= win_data_d;
            last_grant_q <= win_data_d;
            mem_addr_o   <= addr_d;
            we_q         <= win_data_d & d_we_i;
            if (win_data_d && d_we_i) begin
              mem_data_o <= d_data_i;
              mem_wr_no  <= 1'b0;
              mem_rd_no  <= 1'b1;
            end else begin
              mem_wr_no  <= 1'b1;
              mem_rd_no  <= 1'b0;
            end
          end else begin
            state_q   <= ST_IDLE;
            busy_o    <= 1'b0;
            mem_wr_no <= 1'b1;
            mem_rd_no <= 1'b1;
          end
        end
        ST_ACCESS: begin
          state_q   <= ST_DONE;
          mem_wr_no <= 1'b1;
          mem_rd_no <= 1'b1;
          if_ack_o  <= ~grant_o;
          d_ack_o   <= grant_o;
          // Memory registered the word on the negedge; only the winner's register moves
          if (!we_q) begin
            if (grant_o) begin
              d_data_o <= mem_data_i;
            end else begin
              if_data_o <= mem_data_i;
            end
          end
        end
        ST_DONE: begin
          state_q  <= ST_IDLE;
          if_ack_o <= 1'b0;
          d_ack_o  <= 1'b0;
          busy_o   <= 1'b0;
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_wr_no <= 1'b1;
          mem_rd_no <= 1'b1;
          if_ack_o  <= 1'b0;
          d_ack_o   <= 1'b0;
          busy_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule
